// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the button front end and the game FSM.
//   btn_ev_kind_t : event code carried on the event stream
//   trk_state_t   : per-button tracker state
//   DEFAULT_LONG_CYCLES : hold time for a LONG event (1 s at 50 MHz)
// -----------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    EV_PRESS   = 2'd0,
    EV_RELEASE = 2'd1,
    EV_LONG    = 2'd2
  } btn_ev_kind_t;

  typedef enum logic [1:0] {
    TRK_IDLE = 2'd0,
    TRK_DOWN = 2'd1,
    TRK_LONG = 2'd2
  } trk_state_t;

  localparam int DEFAULT_LONG_CYCLES = 50_000_000;

endpackage

// File: rtl/button_event_ctrl_if.sv
// -----------------------------------------------------------------------------
// button_event_ctrl_if
// Valid/ready event stream from the button front end to the game FSM.
//   ev_valid : event available (source -> sink)
//   ev_ready : sink accepts when ev_valid && ev_ready (sink -> source)
//   ev_btn   : index of the button that produced the event
//   ev_kind  : PRESS / RELEASE / LONG
// Modports: master = event source, slave = event sink.
// -----------------------------------------------------------------------------
interface button_event_ctrl_if #(
  parameter int IDX_W = 2
);
  import game_pkg::*;

  logic               ev_valid;
  logic               ev_ready;
  logic [IDX_W-1:0]   ev_btn;
  btn_ev_kind_t       ev_kind;

  modport master (
    output ev_valid,
    output ev_btn,
    output ev_kind,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_btn,
    input  ev_kind,
    output ev_ready
  );

endinterface

// File: rtl/btn_tracker.sv
// -----------------------------------------------------------------------------
// btn_tracker
// Turns one debounced button level into PRESS / LONG / RELEASE pulses.
//   clk     : system clock
//   rst     : synchronous active-low reset
//   level_i : debounced level, 1 = pressed
//   pulse_o : registered one-cycle event pulse
//   kind_o  : event code, valid while pulse_o = 1
// -----------------------------------------------------------------------------
module btn_tracker
  import game_pkg::*;
#(
  parameter int LONG_CYCLES = DEFAULT_LONG_CYCLES,
  parameter int CNT_W       = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         level_i,
  output logic         pulse_o,
  output btn_ev_kind_t kind_o
);

  // The pulse for LONG is registered on the same edge the counter lands on
  // LONG_CYCLES-1, so a press held for LONG_CYCLES samples yields LONG.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LONG_CYCLES - 1);

  trk_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             prev_q;
  logic             pulse_q, pulse_d;
  btn_ev_kind_t     kind_q, kind_d;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned (which would infer a latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    kind_d  = kind_q;
    case (state_q)
      TRK_IDLE: begin
        if (level_i && !prev_q) begin
          pulse_d = 1'b1;
          kind_d  = EV_PRESS;
          cnt_d   = '0;
          state_d = TRK_DOWN;
        end
      end
      TRK_DOWN: begin
        // A fall wins over the threshold on the same cycle.
        if (!level_i) begin
          pulse_d = 1'b1;
          kind_d  = EV_RELEASE;
          state_d = TRK_IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == LAST_CNT) begin
            pulse_d = 1'b1;
            kind_d  = EV_LONG;
            state_d = TRK_LONG;
          end
        end
      end
      TRK_LONG: begin
        // Counter stays frozen until the button is let go.
        if (!level_i) begin
          pulse_d = 1'b1;
          kind_d  = EV_RELEASE;
          state_d = TRK_IDLE;
        end
      end
      default: state_d = TRK_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      state_q <= TRK_IDLE;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
      kind_q  <= EV_PRESS;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= level_i;
      pulse_q <= pulse_d;
      kind_q  <= kind_d;
    end
  end

  assign pulse_o = pulse_q;
  assign kind_o  = kind_q;

endmodule

// File: rtl/button_event_ctrl.sv
// -----------------------------------------------------------------------------
// button_event_ctrl
// Converts N_BTN debounced button levels into a single arbitrated stream of
// PRESS / RELEASE / LONG events.
//   clk       : system clock
//   rst       : synchronous active-low reset
//   btn_level : debounced levels, 1 = pressed
//   ev        : event stream (master side): ev_valid/ev_ready/ev_btn/ev_kind
//   ovf       : sticky, set when an event had to be dropped
//   ovf_clr   : clears ovf (a drop on the same cycle keeps it set)
// Pipeline: tracker pulse -> one-deep pending slot per button -> output reg.
// -----------------------------------------------------------------------------
module button_event_ctrl
  import game_pkg::*;
#(
  parameter int N_BTN       = 4,
  parameter int LONG_CYCLES = DEFAULT_LONG_CYCLES,
  parameter int CNT_W       = 26,
  parameter int IDX_W       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BTN-1:0]     btn_level,
  button_event_ctrl_if.master  ev,
  output logic                 ovf,
  input  logic                 ovf_clr
);

  logic [N_BTN-1:0] trk_pulse;
  btn_ev_kind_t     trk_kind [N_BTN];

  for (genvar g = 0; g < N_BTN; g++) begin : g_trk
    btn_tracker #(
      .LONG_CYCLES (LONG_CYCLES),
      .CNT_W       (CNT_W)
    ) u_trk (
      .clk     (clk),
      .rst     (rst),
      .level_i (btn_level[g]),
      .pulse_o (trk_pulse[g]),
      .kind_o  (trk_kind[g])
    );
  end

  logic [N_BTN-1:0] slot_full_q, slot_full_d;
  btn_ev_kind_t     slot_kind_q [N_BTN];
  btn_ev_kind_t     slot_kind_d [N_BTN];

  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_btn_q, out_btn_d;
  btn_ev_kind_t     out_kind_q, out_kind_d;
  logic             ovf_q, ovf_d;

  logic             out_free;
  logic             any_full;
  logic [IDX_W-1:0] sel_idx;
  logic [N_BTN-1:0] take;
  logic             drop;

  // Output register can take a new event when empty or being accepted now.
  assign out_free = !out_valid_q || ev.ev_ready;

  // Fixed priority: lowest index wins (scan downward so the last hit is lowest).
  always_comb begin
    any_full = 1'b0;
    sel_idx  = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (slot_full_q[i]) begin
        any_full = 1'b1;
        sel_idx  = IDX_W'(i);
      end
    end
  end

  always_comb begin
    take        = '0;
    out_valid_d = out_valid_q;
    out_btn_d   = out_btn_q;
    out_kind_d  = out_kind_q;
    if (out_free) begin
      out_valid_d = any_full;
      if (any_full) begin
        take[sel_idx] = 1'b1;
        out_btn_d     = sel_idx;
        out_kind_d    = slot_kind_q[sel_idx];
      end
    end
  end

  // A slot being emptied into the output this cycle can accept a new pulse.
  always_comb begin
    drop        = 1'b0;
    slot_full_d = slot_full_q;
    slot_kind_d = slot_kind_q;
    for (int i = 0; i < N_BTN; i++) begin
      if (trk_pulse[i]) begin
        if (slot_full_q[i] && !take[i]) begin
          drop = 1'b1;
        end else begin
          slot_full_d[i] = 1'b1;
          slot_kind_d[i] = trk_kind[i];
        end
      end else if (take[i]) begin
        slot_full_d[i] = 1'b0;
      end
    end
    ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: only the full flags must be reset to discard pending events;
      // the kind array is reset as well since it is small and keeps the
      // output register free of unknowns.
      slot_full_q <= '0;
      for (int i = 0; i < N_BTN; i++) slot_kind_q[i] <= EV_PRESS;
      out_valid_q <= 1'b0;
      out_btn_q   <= '0;
      out_kind_q  <= EV_PRESS;
      ovf_q       <= 1'b0;
    end else begin
      slot_full_q <= slot_full_d;
      slot_kind_q <= slot_kind_d;
      out_valid_q <= out_valid_d;
      out_btn_q   <= out_btn_d;
      out_kind_q  <= out_kind_d;
      ovf_q       <= ovf_d;
    end
  end

  assign ev.ev_valid = out_valid_q;
  assign ev.ev_btn   = out_btn_q;
  assign ev.ev_kind  = out_kind_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// -----------------------------------------------------------------------------
// tb_button_event_ctrl
// Directed bench for button_event_ctrl with LONG_CYCLES = 8, N_BTN = 4.
// A per-cycle vector table covers reset and a short press; hand-written
// sequences cover long press, the LONG/RELEASE boundary, arbitration under
// backpressure and overflow. A monitor logs every accepted event.
// -----------------------------------------------------------------------------
module tb_button_event_ctrl;
  import game_pkg::*;

  localparam int N_BTN = 4;
  localparam int LONG  = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N_BTN-1:0] btn_level = '0;
  logic             ovf;
  logic             ovf_clr = 1'b0;

  button_event_ctrl_if #(.IDX_W(2)) ev_if ();

  button_event_ctrl #(
    .N_BTN       (N_BTN),
    .LONG_CYCLES (LONG),
    .CNT_W       (4),
    .IDX_W       (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_level (btn_level),
    .ev        (ev_if),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---- accepted-event monitor ----------------------------------------------
  typedef struct {
    int btn;
    int kind;
    int cyc;
  } ev_t;

  ev_t evq[$];
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change on negedge; half a step later they are settled and the
  // decision for the coming posedge is known.
  always @(negedge clk) begin
    #1;
    if (rst && ev_if.ev_valid && ev_if.ev_ready)
      evq.push_back('{btn: int'(ev_if.ev_btn), kind: int'(ev_if.ev_kind), cyc: cyc});
  end

  task automatic expect_ev(input string name, input int k, input int btn, input btn_ev_kind_t kind);
    if (k >= evq.size()) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: event %0d missing, only %0d logged", name, k, evq.size());
    end else begin
      check({name, ".btn"}, evq[k].btn, btn);
      check({name, ".kind"}, evq[k].kind, int'(kind));
    end
  endtask

  function automatic int ev_gap(input int a, input int b);
    if (a < evq.size() && b < evq.size()) return evq[b].cyc - evq[a].cyc;
    return -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---- vector table ----------------------------------------------------------
  typedef struct {
    logic         rst;
    logic [3:0]   lvl;
    logic         exp_valid;
    logic [1:0]   exp_btn;
    btn_ev_kind_t exp_kind;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic r, input logic [3:0] l, input logic v,
                              input logic [1:0] b, input btn_ev_kind_t k);
    vec_t t;
    t.rst = r; t.lvl = l; t.exp_valid = v; t.exp_btn = b; t.exp_kind = k; t.exp_ovf = 1'b0;
    return t;
  endfunction

  initial begin
    ev_if.ev_ready = 1'b1;

    // Reset with btn 2 held, then a 4-cycle press of btn 0 (ev_ready = 1).
    vecs[0]  = mk(0, 4'b0100, 0, 0, EV_PRESS);
    vecs[1]  = mk(0, 4'b0100, 0, 0, EV_PRESS);
    vecs[2]  = mk(1, 4'b0100, 0, 0, EV_PRESS);   // edge 1: tracker pulse
    vecs[3]  = mk(1, 4'b0100, 0, 0, EV_PRESS);   // edge 2: slot load
    vecs[4]  = mk(1, 4'b0100, 1, 2, EV_PRESS);   // edge 3: output valid
    vecs[5]  = mk(1, 4'b0000, 0, 0, EV_PRESS);
    vecs[6]  = mk(1, 4'b0000, 0, 0, EV_PRESS);
    vecs[7]  = mk(1, 4'b0001, 1, 2, EV_RELEASE);
    vecs[8]  = mk(1, 4'b0001, 0, 0, EV_PRESS);
    vecs[9]  = mk(1, 4'b0001, 1, 0, EV_PRESS);
    vecs[10] = mk(1, 4'b0001, 0, 0, EV_PRESS);
    vecs[11] = mk(1, 4'b0000, 0, 0, EV_PRESS);
    vecs[12] = mk(1, 4'b0000, 0, 0, EV_PRESS);
    vecs[13] = mk(1, 4'b0000, 1, 0, EV_RELEASE);
    vecs[14] = mk(1, 4'b0000, 0, 0, EV_PRESS);
    vecs[15] = mk(1, 4'b0000, 0, 0, EV_PRESS);

    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      rst       = vecs[i].rst;
      btn_level = vecs[i].lvl;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d.valid", i), ev_if.ev_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d.ovf", i), ovf, vecs[i].exp_ovf);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d.btn", i), ev_if.ev_btn, vecs[i].exp_btn);
        check($sformatf("vec%0d.kind", i), int'(ev_if.ev_kind), int'(vecs[i].exp_kind));
      end
      @(negedge clk);
    end
    check("short.count", evq.size(), 4);
    expect_ev("short.e0", 0, 2, EV_PRESS);
    expect_ev("short.e1", 1, 2, EV_RELEASE);
    expect_ev("short.e2", 2, 0, EV_PRESS);
    expect_ev("short.e3", 3, 0, EV_RELEASE);

    // ---- long press: btn 1 high for 20 cycles ----
    evq.delete();
    btn_level = 4'b0010;
    tick(20);
    btn_level = 4'b0000;
    tick(10);
    check("long.count", evq.size(), 3);
    expect_ev("long.e0", 0, 1, EV_PRESS);
    expect_ev("long.e1", 1, 1, EV_LONG);
    expect_ev("long.e2", 2, 1, EV_RELEASE);
    check("long.press_to_long", ev_gap(0, 1), LONG - 1);
    check("long.press_to_release", ev_gap(0, 2), 20);

    // ---- boundary: level falls on the cycle the counter would hit 7 ----
    evq.delete();
    btn_level = 4'b0010;
    tick(LONG - 1);
    btn_level = 4'b0000;
    tick(10);
    check("bound.count", evq.size(), 2);
    expect_ev("bound.e0", 0, 1, EV_PRESS);
    expect_ev("bound.e1", 1, 1, EV_RELEASE);
    check("bound.gap", ev_gap(0, 1), LONG - 1);

    // ---- arbitration under backpressure: btn 3 and btn 0 together ----
    evq.delete();
    ev_if.ev_ready = 1'b0;
    btn_level      = 4'b1001;
    tick(3);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("arb.hold%0d.valid", c), ev_if.ev_valid, 1);
      check($sformatf("arb.hold%0d.btn", c), ev_if.ev_btn, 0);
      check($sformatf("arb.hold%0d.kind", c), int'(ev_if.ev_kind), int'(EV_PRESS));
      if (c < 2) tick(1);
    end
    ev_if.ev_ready = 1'b1;
    btn_level      = 4'b0000;
    tick(10);
    check("arb.count", evq.size(), 4);
    expect_ev("arb.e0", 0, 0, EV_PRESS);
    expect_ev("arb.e1", 1, 3, EV_PRESS);
    expect_ev("arb.e2", 2, 0, EV_RELEASE);
    expect_ev("arb.e3", 3, 3, EV_RELEASE);
    check("arb.back_to_back", ev_gap(0, 1), 1);
    check("arb.ovf", ovf, 0);

    // ---- overflow: btn 0 RELEASE arrives while its PRESS is still pending ----
    evq.delete();
    ev_if.ev_ready = 1'b0;
    btn_level      = 4'b0010;   // btn 1 will occupy the output register
    tick(1);
    btn_level      = 4'b0011;   // btn 0 PRESS lands in its slot
    tick(1);
    btn_level      = 4'b0010;   // btn 0 RELEASE finds the slot full
    tick(2);
    check("ovf.set", ovf, 1);
    check("ovf.out_valid", ev_if.ev_valid, 1);
    check("ovf.out_btn", ev_if.ev_btn, 1);
    tick(1);
    check("ovf.sticky", ovf, 1);
    ovf_clr = 1'b1;
    tick(1);
    check("ovf.cleared", ovf, 0);
    ovf_clr        = 1'b0;
    ev_if.ev_ready = 1'b1;
    btn_level      = 4'b0000;
    tick(10);
    check("ovf.count", evq.size(), 3);
    expect_ev("ovf.e0", 0, 1, EV_PRESS);
    expect_ev("ovf.e1", 1, 0, EV_PRESS);
    expect_ev("ovf.e2", 2, 1, EV_RELEASE);
    check("ovf.stays_clear", ovf, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/button_event_ctrl.md
Name: button_event_ctrl

Overview:
- Consumes the debounced, clean button levels (one per player button: select card, confirm, call truco, fold).
- Converts each level into discrete PRESS / LONG / RELEASE events.
- Arbitrates all buttons into a single event stream with a valid/ready handshake toward the game FSM.
- Sits directly downstream of the per-button debounce instances and upstream of the game control FSM.

Parameters:
- N_BTN, 4, number of button inputs.
- LONG_CYCLES, 50_000_000, hold duration in clk cycles (1 s at 50 MHz) that generates a LONG event; must be >= 2.
- CNT_W, 26, hold-counter width; must satisfy 2^CNT_W > LONG_CYCLES.
- IDX_W, 2, event button-index width; must equal clog2(N_BTN).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- btn_level  in  N_BTN  debounced button levels, 1 = pressed; already synchronous to clk.
- ev_valid  out  1  event available.
- ev_ready  in  1  consumer accepts the event on a cycle where ev_valid && ev_ready.
- ev_btn  out  IDX_W  index of the button that produced the event.
- ev_kind  out  2  event code: 0 = PRESS, 1 = RELEASE, 2 = LONG (3 unused).
- ovf  out  1  sticky flag: an event was dropped.
- ovf_clr  in  1  clears ovf; a simultaneous new drop wins, leaving ovf = 1.

Behaviour:

Reset (rst = 0 at a clk edge):
- ev_valid = 0, ev_btn = 0, ev_kind = 0, ovf = 0.
- All trackers go to IDLE; prev_level = 0; hold counters = 0; all pending slots empty.
- Reset mid-operation discards any held or pending events without emitting them.

Per-button tracker FSM (IDLE, DOWN, LONG_HELD), with prev_level registered each cycle:
- IDLE: on btn_level = 1 with prev_level = 0, pulse PRESS, clear the counter, go to DOWN.
  - A button held through reset therefore yields a PRESS on the first cycle after reset.
- DOWN: the counter increments each cycle.
  - When the counter reaches LONG_CYCLES-1 with the level still 1, pulse LONG and go to LONG_HELD.
  - On level 0, pulse RELEASE and go to IDLE.
  - If the level falls on the same cycle the threshold would be reached, only RELEASE is generated.
- LONG_HELD: the counter is frozen. On level 0, pulse RELEASE and go to IDLE.
- Tracker output is a registered one-cycle pulse plus a 2-bit kind; at most one pulse per button per cycle.

Pending slots (one per button, one entry deep):
- A tracker pulse loads the button's slot.
- If the slot is full and is not being transferred to the output this cycle, the new event is dropped, the old one is kept, and ovf is set.
- A slot transferred to the output in the same cycle as a new pulse accepts the new pulse (no drop).

Output register and arbitration:
- The output register is loaded when it is empty, or when the current event is accepted (ev_valid && ev_ready).
- It is loaded from the lowest-index non-empty slot; that slot is cleared.
- ev_btn and ev_kind are held stable while ev_valid && !ev_ready.
- Back-to-back accepts give one event per cycle.

Latency: with the stream idle, ev_valid rises 3 clk edges after the first edge that samples btn_level[i] = 1:
- edge 1: tracker pulse;
- edge 2: slot load;
- edge 3: output load.

Decomposition:
- Shared package game_pkg holds:
  - typedef enum logic [1:0] btn_ev_kind_t {EV_PRESS = 0, EV_RELEASE = 1, EV_LONG = 2};
  - typedef enum for tracker states {TRK_IDLE, TRK_DOWN, TRK_LONG};
  - the default LONG_CYCLES constant.
- Sub-module btn_tracker (one instance per button) holds the FSM, the counter, prev_level, and the pulse/kind outputs.
- Pending slots, arbiter, output register and ovf live in the top.

Test Plan (LONG_CYCLES = 8, N_BTN = 4, ev_ready = 1 unless stated):
- Reset: btn_level[2] held 1 during rst = 0, release rst -> ev_valid at edge 3 after reset with ev_btn = 2, ev_kind = PRESS; ovf = 0.
- Short press: btn_level[0] high for 4 cycles then low -> exactly PRESS then RELEASE for btn 0, no LONG.
- Long press: btn_level[1] high for 20 cycles -> PRESS, then LONG when the counter hits 7, then RELEASE after the fall; exactly 3 events.
- Boundary: btn_level[1] falls on the cycle the counter reaches 7 -> PRESS, RELEASE only.
- Arbitration/backpressure: btn 3 and btn 0 rise on the same cycle, ev_ready = 0 for 5 cycles -> btn 0 PRESS is held stable; after ev_ready = 1, btn 0 is accepted first, then btn 3 on the next cycle.
- Overflow: ev_ready = 0, btn 0 PRESS then RELEASE while the PRESS is still pending in the slot (output full) -> RELEASE dropped, ovf = 1; ovf_clr pulse -> ovf = 0.
